// File: rtl/freq_div_checker_pkg.sv
// ---------------------------------------------------------------------------
// freq_div_pkg: shared state encoding, default window constants and count helpers
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package freq_div_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    FAULT   = 2'd3
  } state_e;

  // A divide-by-1.5 clock yields two pulses and two high half-phases per 3 source cycles
  function automatic int unsigned exp_count(input int unsigned window_cyc);
    return (2 * window_cyc) / 3;
  endfunction

  function automatic logic within_tol(input int unsigned val,
                                      input int unsigned exp_val,
                                      input int unsigned tol);
    int unsigned diff;
    diff = (val > exp_val) ? (val - exp_val) : (exp_val - val);
    return (diff <= tol);
  endfunction

  localparam int unsigned WINDOW_CYC_DEF = 24;
  localparam int unsigned EXP_EDGES_DEF  = exp_count(WINDOW_CYC_DEF);
  localparam int unsigned EXP_HIGH_DEF   = exp_count(WINDOW_CYC_DEF);

endpackage

`default_nettype wire

// File: rtl/freq_div_checker_if.sv
// ---------------------------------------------------------------------------
// freq_div_checker_if: enable/clock-under-test inputs and measurement status
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface freq_div_checker_if #(
  parameter int CNT_W = 8
);
  logic             en;
  logic             div_in;
  logic [CNT_W-1:0] edge_cnt;
  logic [CNT_W-1:0] high_cnt;
  logic             meas_valid;
  logic             lock;
  logic             err;

  modport master (
    output en, div_in,
    input  edge_cnt, high_cnt, meas_valid, lock, err
  );

  modport slave (
    input  en, div_in,
    output edge_cnt, high_cnt, meas_valid, lock, err
  );
endinterface

`default_nettype wire

// File: rtl/freq_div_checker_sampler.sv
// ---------------------------------------------------------------------------
// dual_edge_sampler: captures div_in on both clk edges, presents p/a/b half-phases
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module dual_edge_sampler (
  input  wire logic clk_i,
  input  wire logic rst_ni,
  input  wire logic d_i,
  output logic      p_o,
  output logic      a_o,
  output logic      b_o
);

  logic sr_q;
  logic sf_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sr_q <= 1'b0;
    else         sr_q <= d_i;
  end

  always_ff @(negedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sf_q <= 1'b0;
    else         sf_q <= d_i;
  end

  // b is the sample this posedge is about to capture, so it is taken straight from d_i
  assign p_o = sr_q;
  assign a_o = sf_q;
  assign b_o = d_i;

endmodule

`default_nettype wire

// File: rtl/freq_div_checker.sv
// ---------------------------------------------------------------------------
// freq_div_checker: windowed edge/duty measurement of a divide-by-1.5 clock
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module freq_div_checker
  import freq_div_pkg::*;
#(
  parameter int unsigned WINDOW_CYC   = WINDOW_CYC_DEF,
  parameter int unsigned EXP_EDGES    = exp_count(WINDOW_CYC),
  parameter int unsigned EXP_HIGH     = exp_count(WINDOW_CYC),
  parameter int unsigned TOL          = 0,
  parameter int unsigned LOCK_WINDOWS = 2,
  parameter int unsigned CNT_W        = 8
) (
  input wire logic           clk_i,
  input wire logic           rst_ni,
  freq_div_checker_if.slave  bus
);

  localparam int unsigned WIN_W = (WINDOW_CYC > 1) ? $clog2(WINDOW_CYC) : 1;
  localparam int unsigned MC_W  = (LOCK_WINDOWS > 0) ? $clog2(LOCK_WINDOWS + 1) : 1;

  logic p_w, a_w, b_w;

  dual_edge_sampler u_sampler (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (bus.div_in),
    .p_o    (p_w),
    .a_o    (a_w),
    .b_o    (b_w)
  );

  state_e           state_q;
  logic [WIN_W-1:0] win_q;
  logic [CNT_W-1:0] edge_acc_q, high_acc_q;
  logic [CNT_W-1:0] edge_cnt_q, high_cnt_q;
  logic [MC_W-1:0]  match_q;
  logic             valid_q, lock_q, err_q;

  logic             rise_w;
  logic [1:0]       high_w;
  logic [CNT_W:0]   edge_sum_w, high_sum_w;
  logic [CNT_W-1:0] edge_tot_d, high_tot_d;
  logic             match_w;
  logic             win_last_w;

  // Ordered half-phases p,a,b: a rising edge lies between p/a or between a/b
  assign rise_w = (~p_w & a_w) | (~a_w & b_w);
  assign high_w = {1'b0, a_w} + {1'b0, b_w};

  assign edge_sum_w = {1'b0, edge_acc_q} + {{CNT_W{1'b0}}, rise_w};
  assign high_sum_w = {1'b0, high_acc_q} + {{(CNT_W-1){1'b0}}, high_w};
  assign edge_tot_d = edge_sum_w[CNT_W] ? {CNT_W{1'b1}} : edge_sum_w[CNT_W-1:0];
  assign high_tot_d = high_sum_w[CNT_W] ? {CNT_W{1'b1}} : high_sum_w[CNT_W-1:0];

  assign match_w    = within_tol(32'(edge_tot_d), EXP_EDGES, TOL) &&
                      within_tol(32'(high_tot_d), EXP_HIGH,  TOL);
  assign win_last_w = (win_q == WIN_W'(WINDOW_CYC - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      win_q      <= '0;
      edge_acc_q <= '0;
      high_acc_q <= '0;
      edge_cnt_q <= '0;
      high_cnt_q <= '0;
      match_q    <= '0;
      valid_q    <= 1'b0;
      lock_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      // Dropping en discards the partial window and all status, even on a window-end edge
      if (!bus.en) begin
        state_q    <= IDLE;
        win_q      <= '0;
        edge_acc_q <= '0;
        high_acc_q <= '0;
        edge_cnt_q <= '0;
        high_cnt_q <= '0;
        match_q    <= '0;
        lock_q     <= 1'b0;
        err_q      <= 1'b0;
      end else if (state_q == IDLE) begin
        state_q    <= ACQUIRE;
        win_q      <= '0;
        edge_acc_q <= '0;
        high_acc_q <= '0;
      end else if (win_last_w) begin
        win_q      <= '0;
        edge_acc_q <= '0;
        high_acc_q <= '0;
        edge_cnt_q <= edge_tot_d;
        high_cnt_q <= high_tot_d;
        valid_q    <= 1'b1;
        case (state_q)
          ACQUIRE: begin
            if (!match_w) begin
              match_q <= '0;
            end else if (match_q == MC_W'(LOCK_WINDOWS - 1)) begin
              match_q <= '0;
              state_q <= LOCKED;
              lock_q  <= 1'b1;
            end else begin
              match_q <= match_q + MC_W'(1);
            end
          end
          LOCKED: begin
            if (!match_w) begin
              state_q <= FAULT;
              lock_q  <= 1'b0;
              err_q   <= 1'b1;
            end
          end
          default: begin
          end
        endcase
      end else begin
        win_q      <= win_q + WIN_W'(1);
        edge_acc_q <= edge_tot_d;
        high_acc_q <= high_tot_d;
      end
    end
  end

  assign bus.edge_cnt   = edge_cnt_q;
  assign bus.high_cnt   = high_cnt_q;
  assign bus.meas_valid = valid_q;
  assign bus.lock       = lock_q;
  assign bus.err        = err_q;

endmodule

`default_nettype wire

// File: tb/tb_freq_div_checker.sv
// ---------------------------------------------------------------------------
// tb_freq_div_checker: directed scenarios with a queue-based window scoreboard
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_freq_div_checker;
  import freq_div_pkg::*;

  localparam int CNT_W = 8;
  localparam logic [1:0] M_NOM   = 2'd0;
  localparam logic [1:0] M_STUCK = 2'd1;
  localparam logic [1:0] M_HALF  = 2'd2;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       en_r    = 1'b0;
  logic       div_src = 1'b0;
  logic [1:0] mode    = M_NOM;
  logic [1:0] prev_mode = M_NOM;
  int         ph = 0;

  freq_div_checker_if #(.CNT_W(CNT_W)) bus ();
  assign bus.en     = en_r;
  assign bus.div_in = div_src;

  freq_div_checker #(
    .WINDOW_CYC   (24),
    .EXP_EDGES    (16),
    .EXP_HIGH     (16),
    .TOL          (0),
    .LOCK_WINDOWS (2),
    .CNT_W        (CNT_W)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #20 clk = ~clk;

  // Source model: nominal is a divide-by-1.5 with half-phase pattern H L L repeating
  always @(clk) begin
    #5;
    if (mode == M_NOM && prev_mode != M_NOM) ph = 0;
    prev_mode = mode;
    case (mode)
      M_NOM: begin
        div_src = (ph == 0) || (ph == 3);
        ph      = (ph == 5) ? 0 : ph + 1;
      end
      M_STUCK: div_src = 1'b0;
      default: if (clk) div_src = ~div_src;
    endcase
  end

  typedef struct packed {
    logic [7:0] e;
    logic [7:0] h;
    logic       lk;
    logic       er;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic push(input int e, input int h, input int lk, input int er);
    exp_t x;
    x.e  = 8'(e);
    x.h  = 8'(h);
    x.lk = lk[0];
    x.er = er[0];
    sb_q.push_back(x);
  endtask

  // Returns at posedge+1 of the next meas_valid so source-mode changes land before the new window
  task automatic wait_meas(input int exp_lat, input string name);
    int n;
    bit seen;
    n = 0;
    seen = 0;
    while (!seen && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.meas_valid) seen = 1;
    end
    check({name, "_latency"}, n, exp_lat);
  endtask

  task automatic check_idle(input string name);
    check({name, "_lock"},  int'(bus.lock), 0);
    check({name, "_err"},   int'(bus.err), 0);
    check({name, "_valid"}, int'(bus.meas_valid), 0);
    check({name, "_edge"},  int'(bus.edge_cnt), 0);
    check({name, "_high"},  int'(bus.high_cnt), 0);
    check({name, "_state"}, int'(dut.state_q), int'(IDLE));
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.meas_valid) begin
      exp_t x;
      if (sb_q.size() == 0) begin
        check("unexpected_meas_valid", 1, 0);
      end else begin
        x = sb_q.pop_front();
        check("sb_edge_cnt", int'(bus.edge_cnt), int'(x.e));
        check("sb_high_cnt", int'(bus.high_cnt), int'(x.h));
        check("sb_lock",     int'(bus.lock),     int'(x.lk));
        check("sb_err",      int'(bus.err),      int'(x.er));
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    @(negedge clk) en_r = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset_en_high");
    @(negedge clk);
    en_r  = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Nominal lock, then stuck input, then restore: err must stay sticky
    push(16, 16, 0, 0);
    push(16, 16, 1, 0);
    push(16, 16, 1, 0);
    @(negedge clk) en_r = 1'b1;
    wait_meas(25, "nom_w1");
    wait_meas(24, "nom_w2");
    wait_meas(24, "nom_w3");
    mode = M_STUCK;
    push(0, 0, 0, 1);
    wait_meas(24, "stuck");
    mode = M_NOM;
    push(16, 16, 0, 1);
    wait_meas(24, "restore1");
    push(16, 16, 0, 1);
    wait_meas(24, "restore2");
    @(negedge clk) en_r = 1'b0;
    @(posedge clk);
    #1;
    check_idle("en_drop");

    // Abort a window after 10 cycles, then re-enable for a clean window
    @(negedge clk) en_r = 1'b1;
    repeat (11) @(posedge clk);
    @(negedge clk) en_r = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("abort");
    check("abort_sb_empty", sb_q.size(), 0);
    push(16, 16, 0, 0);
    push(16, 16, 1, 0);
    @(negedge clk) en_r = 1'b1;
    wait_meas(25, "reen_w1");
    wait_meas(24, "reen_w2");

    // Asynchronous reset while locked, en held high throughout
    repeat (7) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    check_idle("midrst");
    repeat (2) @(posedge clk);
    push(16, 16, 0, 0);
    push(16, 16, 1, 0);
    @(negedge clk) rst_n = 1'b1;
    wait_meas(25, "rst_w1");
    wait_meas(24, "rst_w2");

    // clk/2 source: wrong ratio never locks and never flags err
    @(negedge clk);
    en_r = 1'b0;
    mode = M_HALF;
    repeat (4) @(posedge clk);
    push(12, 24, 0, 0);
    push(12, 24, 0, 0);
    push(12, 24, 0, 0);
    @(negedge clk) en_r = 1'b1;
    wait_meas(25, "half_w1");
    wait_meas(24, "half_w2");
    wait_meas(24, "half_w3");
    @(negedge clk) en_r = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("final_sb_empty", sb_q.size(), 0);
    check("final_lock", int'(bus.lock), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
